// File: rtl/color_sensor_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_sensor_scanner                                                 |
// | TCS3200-class filter sequencer, gated edge counter and classifier.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module color_sensor_scanner #(
  parameter int         GATE_CYCLES   = 12_500_000,
  parameter int         SETTLE_CYCLES = 100_000,
  parameter int         CNT_W         = 25,
  parameter int         SCALE_SHIFT   = 3,
  parameter int         NUM_CH        = 3,
  parameter logic [1:0] FREQ_SCALE    = 2'b10,
  parameter int         MIN_LEVEL     = 700
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             freq_in,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             oe_n,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [3:0]       ovf,
  output logic [1:0]       color_class,
  output logic             frame_valid
);

  localparam int c_tmax = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax + 1) : 1;

  localparam logic [c_tw-1:0]  c_settle_last = c_tw'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [c_tw-1:0]  c_gate_last   = c_tw'(GATE_CYCLES - 1);
  localparam logic [1:0]       c_last_ch     = 2'(NUM_CH - 1);
  localparam logic             c_no_settle   = (SETTLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;
  localparam logic [63:0]      c_min_level   = 64'(MIN_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_GATE     = 3'd2,
    S_STORE    = 3'd3,
    S_CLASSIFY = 3'd4,
    S_PUBLISH  = 3'd5
  } state_t;

  state_t           r_state;
  logic [c_tw-1:0]  r_timer;
  logic [1:0]       r_ch;
  logic [CNT_W-1:0] r_raw;
  logic [CNT_W-1:0] r_shadow [4];
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_prev;

  logic             w_edge;
  logic [CNT_W-1:0] w_scaled;
  logic             w_scale_sat;
  logic [1:0]       w_class;

  // Filter select order R, B, G, C maps to {s2,s3} = 00, 01, 11, 10.
  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      2'd0:    filter_code = 2'b00;
      2'd1:    filter_code = 2'b01;
      2'd2:    filter_code = 2'b11;
      default: filter_code = 2'b10;
    endcase
  endfunction

  assign s0 = FREQ_SCALE[1];
  assign s1 = FREQ_SCALE[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= freq_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync_prev;

  generate
    if (SCALE_SHIFT == 0) begin : g_no_shift
      assign w_scaled    = r_raw;
      assign w_scale_sat = 1'b0;
    end else begin : g_shift
      logic [CNT_W+SCALE_SHIFT-1:0] w_wide;
      assign w_wide      = {r_raw, {SCALE_SHIFT{1'b0}}};
      assign w_scale_sat = |w_wide[CNT_W+SCALE_SHIFT-1:CNT_W];
      assign w_scaled    = w_scale_sat ? c_cnt_max : w_wide[CNT_W-1:0];
    end
  endgenerate

  // Only the R/B/G shadows take part; a tie for the maximum is no winner.
  always_comb begin
    w_class = 2'd0;
    if ((r_shadow[0] > r_shadow[1]) && (r_shadow[0] > r_shadow[2])) begin
      if (64'(r_shadow[0]) > c_min_level) w_class = 2'd1;
    end else if ((r_shadow[2] > r_shadow[0]) && (r_shadow[2] > r_shadow[1])) begin
      if (64'(r_shadow[2]) > c_min_level) w_class = 2'd2;
    end else if ((r_shadow[1] > r_shadow[0]) && (r_shadow[1] > r_shadow[2])) begin
      if (64'(r_shadow[1]) > c_min_level) w_class = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_ch        <= 2'd0;
      r_raw       <= '0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      oe_n        <= 1'b1;
      red_cnt     <= '0;
      blue_cnt    <= '0;
      green_cnt   <= '0;
      clear_cnt   <= '0;
      ovf         <= 4'd0;
      color_class <= 2'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (!enable) begin
        // Abort: the partial frame is dropped, published outputs stay put.
        r_state <= S_IDLE;
        r_timer <= '0;
        r_ch    <= 2'd0;
        r_raw   <= '0;
        for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
        ovf     <= 4'd0;
        {s2, s3} <= 2'b00;
        oe_n    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_PUBLISH: begin
            oe_n     <= 1'b0;
            ovf      <= 4'd0;
            r_ch     <= 2'd0;
            {s2, s3} <= filter_code(2'd0);
            r_timer  <= '0;
            r_raw    <= '0;
            r_state  <= c_no_settle ? S_GATE : S_SETTLE;
          end
          S_SETTLE: begin
            r_raw <= '0;
            if (r_timer == c_settle_last) begin
              r_timer <= '0;
              r_state <= S_GATE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_GATE: begin
            if (w_edge) begin
              if (r_raw == c_cnt_max) ovf[r_ch] <= 1'b1;
              else                    r_raw     <= r_raw + 1'b1;
            end
            if (r_timer == c_gate_last) begin
              r_timer <= '0;
              r_state <= S_STORE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_STORE: begin
            r_shadow[r_ch] <= w_scaled;
            if (w_scale_sat) ovf[r_ch] <= 1'b1;
            r_raw <= '0;
            if (r_ch == c_last_ch) begin
              r_state <= S_CLASSIFY;
            end else begin
              r_ch     <= r_ch + 2'd1;
              {s2, s3} <= filter_code(r_ch + 2'd1);
              r_timer  <= '0;
              r_state  <= c_no_settle ? S_GATE : S_SETTLE;
            end
          end
          S_CLASSIFY: begin
            // Outputs and strobe land together in the PUBLISH cycle.
            red_cnt     <= r_shadow[0];
            blue_cnt    <= r_shadow[1];
            green_cnt   <= r_shadow[2];
            clear_cnt   <= r_shadow[3];
            color_class <= w_class;
            frame_valid <= 1'b1;
            r_state     <= S_PUBLISH;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_sensor_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_color_sensor_scanner                                              |
// | Directed vector bench for the colour sensor scanner.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_color_sensor_scanner;

  localparam int GATE   = 100;
  localparam int SETTLE = 10;
  localparam int CH_LEN = SETTLE + GATE + 1;
  localparam int FRAME  = 3 * CH_LEN + 2;
  localparam int CW     = 25;
  localparam int CW4    = 4;

  typedef struct {
    int         pr, pb, pg;
    int         er, eb, eg;
    logic [1:0] ec;
  } vec_t;

  logic          clk, rst_n, enable, enable4;
  logic          freq_in, freq_in4;
  logic          s0, s1, s2, s3, oe_n, fv;
  logic [CW-1:0] red, blue, green, clear;
  logic [3:0]    ovf;
  logic [1:0]    cls;
  logic           s0_4, s1_4, s2_4, s3_4, oe_n4, fv4;
  logic [CW4-1:0] red4, blue4, green4, clear4;
  logic [3:0]     ovf4;
  logic [1:0]     cls4;

  int   checks = 0;
  int   failures = 0;
  int   per_r, per_b, per_g, per4;
  logic gen_val, gen_val4, burst_mode, burst_val;
  vec_t vecs [7];

  assign freq_in  = burst_mode ? burst_val : gen_val;
  assign freq_in4 = gen_val4;

  color_sensor_scanner #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CW),
                         .SCALE_SHIFT(0), .NUM_CH(3), .FREQ_SCALE(2'b10), .MIN_LEVEL(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq_in(freq_in),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .oe_n(oe_n),
    .red_cnt(red), .blue_cnt(blue), .green_cnt(green), .clear_cnt(clear),
    .ovf(ovf), .color_class(cls), .frame_valid(fv));

  color_sensor_scanner #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CW4),
                         .SCALE_SHIFT(0), .NUM_CH(3), .FREQ_SCALE(2'b10), .MIN_LEVEL(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .freq_in(freq_in4),
    .s0(s0_4), .s1(s1_4), .s2(s2_4), .s3(s3_4), .oe_n(oe_n4),
    .red_cnt(red4), .blue_cnt(blue4), .green_cnt(green4), .clear_cnt(clear4),
    .ovf(ovf4), .color_class(cls4), .frame_valid(fv4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Periodic source: period chosen by the filter currently selected.
  initial begin
    int ph, last, p;
    ph = 0; last = 0; gen_val = 1'b0;
    forever begin
      @(negedge clk);
      case ({s2, s3})
        2'b00:   p = per_r;
        2'b01:   p = per_b;
        2'b11:   p = per_g;
        default: p = 0;
      endcase
      if (oe_n) p = 0;
      if (p != last) begin ph = 0; last = p; end
      else if (p != 0) ph = (ph == p - 1) ? 0 : ph + 1;
      gen_val = (p != 0) && (ph < p / 2);
    end
  end

  initial begin
    int ph, last, p;
    ph = 0; last = 0; gen_val4 = 1'b0;
    forever begin
      @(negedge clk);
      p = ({s2_4, s3_4} == 2'b00 && !oe_n4) ? per4 : 0;
      if (p != last) begin ph = 0; last = p; end
      else if (p != 0) ph = (ph == p - 1) ? 0 : ph + 1;
      gen_val4 = (p != 0) && (ph < p / 2);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fv(input bit use4, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(use4 ? fv4 : fv) && cyc < max_cyc);
    check(use4 ? "fv4_seen" : "fv_seen", use4 ? fv4 : fv, 1);
  endtask

  // Cycle-exact stimulus for one frame, started on the negedge where fv was seen.
  task automatic burst_frame(input int nr, input int nb, input int ng, input bit settle_tog);
    int c, l, n;
    burst_mode = 1'b1;
    burst_val  = 1'b0;
    for (int k = 0; k < 3 * CH_LEN; k++) begin
      @(negedge clk);
      if (k == 0) check("fv_pulse_width", fv, 0);
      c = k / CH_LEN;
      l = k % CH_LEN;
      n = (c == 0) ? nr : (c == 1) ? nb : ng;
      if (l < SETTLE) burst_val = settle_tog && (l % 2 == 0) && (l < 8);
      else            burst_val = (l >= 20) && ((l - 20) % 4 < 2) && ((l - 20) / 4 < n);
    end
  endtask

  task automatic check_frame(input string tag, input int er, input int eb, input int eg,
                             input logic [1:0] ec);
    check({tag, "_red"}, red, er);
    check({tag, "_blue"}, blue, eb);
    check({tag, "_green"}, green, eg);
    check({tag, "_class"}, cls, ec);
  endtask

  initial begin
    int cyc, hits;

    vecs[0] = '{10, 4, 20, 10, 25, 5, 2'd3};
    vecs[1] = '{5, 25, 5, 20, 4, 20, 2'd0};
    vecs[2] = '{4, 0, 10, 25, 0, 10, 2'd1};
    vecs[3] = '{20, 4, 2, 5, 25, 50, 2'd2};
    vecs[4] = '{50, 50, 25, 2, 2, 4, 2'd0};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 2'd0};
    vecs[6] = '{2, 4, 4, 50, 25, 25, 2'd1};

    rst_n = 1'b0; enable = 1'b0; enable4 = 1'b0;
    burst_mode = 1'b0; burst_val = 1'b0;
    per_r = 0; per_b = 0; per_g = 0; per4 = 0;
    repeat (3) @(negedge clk);
    check("rst_pins", {oe_n, s2, s3, s0, s1}, 5'b10010);
    check("rst_counts", {red, blue, green, clear}, 0);
    check("rst_ovf_class_fv", {ovf, cls, fv}, 0);

    // Table: periods are swapped on the publish cycle so each next frame is clean.
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      per_r = vecs[i].pr; per_b = vecs[i].pb; per_g = vecs[i].pg;
      wait_fv(1'b0, FRAME + 10, cyc);
      check($sformatf("v%0d_frame_len", i), cyc, FRAME);
      check_frame($sformatf("v%0d", i), vecs[i].er, vecs[i].eb, vecs[i].eg, vecs[i].ec);
      check($sformatf("v%0d_ovf", i), ovf, 0);
      check($sformatf("v%0d_clear", i), clear, 0);
    end

    // Toggles only inside every settle window: nothing may be counted.
    burst_frame(0, 0, 0, 1'b1);
    wait_fv(1'b0, 10, cyc);
    check("settle_only_lat", cyc, 2);
    check_frame("settle_only", 0, 0, 0, 2'd0);

    burst_frame(20, 3, 20, 1'b0);
    wait_fv(1'b0, 10, cyc);
    check_frame("tie_rg", 20, 3, 20, 2'd0);

    burst_frame(3, 4, 3, 1'b0);
    wait_fv(1'b0, 10, cyc);
    check_frame("below_min", 3, 4, 3, 2'd0);

    // Abort during the green gate, then restart.
    burst_mode = 1'b0;
    per_r = 10; per_b = 4; per_g = 20;
    hits = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (fv) hits++;
    end
    enable = 1'b0;
    @(negedge clk);
    check("abort_pins", {oe_n, s2, s3}, 3'b100);
    check_frame("abort_hold", 3, 4, 3, 2'd0);
    check("abort_ovf", ovf, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fv) hits++;
    end
    check("abort_no_fv", hits, 0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_pins", {oe_n, s2, s3}, 3'b000);
    wait_fv(1'b0, FRAME + 10, cyc);
    check("reenable_len", cyc, FRAME - 1);
    check_frame("reenable", 10, 25, 5, 2'd3);

    // Narrow counter: saturation and overflow, then recovery next frame.
    per4 = 2;
    enable4 = 1'b1;
    wait_fv(1'b1, FRAME + 10, cyc);
    check("sat_len", cyc, FRAME);
    check("sat_red", red4, 15);
    check("sat_ovf", ovf4, 4'b0001);
    check("sat_class", cls4, 2'd1);
    per4 = 25;
    wait_fv(1'b1, FRAME + 10, cyc);
    check("unsat_red", red4, 4);
    check("unsat_ovf", ovf4, 4'b0000);
    check("unsat_class", cls4, 2'd0);

    // Asynchronous reset in the middle of the red gate.
    wait_fv(1'b0, FRAME + 10, cyc);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pins", {oe_n, s2, s3}, 3'b100);
    check("arst_counts", {red, blue, green, clear}, 0);
    check("arst_ovf_class_fv", {ovf, cls, fv}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fv(1'b0, FRAME + 10, cyc);
    check("arst_first_len", cyc, FRAME);
    check_frame("arst_first", 10, 25, 5, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
